sm_fifo_pair: RTL and testbench
===============================

// Module: sm_fifo_pair
// PURPOSE
//  Per-state-machine TX/RX FIFO pair; successor to the single fixed 4x32 fifo.
//  TX: system pushes, state machine pulls (OSR feed). RX: state machine pushes (ISR), system pops.
//  Adds parametrised width/depth, join modes pooling both FIFOs' storage into one
//  direction (2*DEPTH), sticky overflow/underflow flags and a flush on mode change.
// PARAMETERS
//  WIDTH  32                      data word width
//  DEPTH  4                       entries per FIFO when unjoined; power of 2, >=2
//  CNT_W  $clog2(2*DEPTH)+1       width of count outputs
// PORTS
//  clk          in   1      clock
//  rst          in   1      asynchronous, active-low reset
//  join_mode    in   2      fifo_join_t: JOIN_NONE=0, JOIN_TX=1, JOIN_RX=2; 3 treated as JOIN_NONE
//  tx_push_en   in   1      system pushes tx_data_in
//  tx_data_in   in   WIDTH  TX write data
//  tx_pull_en   in   1      state machine pops TX head
//  tx_data_out  out  WIDTH  TX head word, first-word-fall-through
//  rx_push_en   in   1      state machine pushes rx_data_in
//  rx_data_in   in   WIDTH  RX write data
//  rx_pop_en    in   1      system pops RX head
//  rx_data_out  out  WIDTH  RX head word, first-word-fall-through
//  tx_status    out  2      fifo_status {full, empty}
//  rx_status    out  2      fifo_status {full, empty}
//  tx_count     out  CNT_W  TX occupancy
//  rx_count     out  CNT_W  RX occupancy
//  err_clr      in   1      clears all sticky error flags
//  tx_overflow  out  1      sticky: push while TX full
//  tx_underflow out  1      sticky: pull while TX empty
//  rx_overflow  out  1      sticky: push while RX full
//  rx_underflow out  1      sticky: pop while RX empty
// BEHAVIOUR
//  - Reset (rst=0, async): pointers and counts 0, registered mode = JOIN_NONE, flags 0;
//    empty=1, full=0, data_out=0. Storage contents are not reset.
//  - Storage: one 2*DEPTH x WIDTH array.
//    JOIN_NONE: TX uses entries 0..DEPTH-1, RX uses DEPTH..2*DEPTH-1, capacity DEPTH each.
//    JOIN_TX: TX uses all entries, capacity 2*DEPTH. JOIN_RX: same for RX.
//  - Disabled FIFO (RX in JOIN_TX, TX in JOIN_RX): count=0, empty=1, full=1.
//    Its push/pop/pull is ignored, no error flag set, data_out=0.
//  - Push: write at tail and advance it on the rising edge; visible at data_out the next
//    cycle if the FIFO was empty. Pointers wrap modulo the current capacity.
//  - Pop/pull: advance head at the edge; data_out always shows mem[head] when count>0, else 0.
//  - Latency: push-to-data_out 1 cycle. No same-cycle bypass of an empty FIFO.
//  - Push when full (no pop): dropped; overflow flag set.
//  - Pop when empty: no pointer change; underflow flag set.
//  - Push+pop, full: both occur, count unchanged, no overflow.
//  - Push+pop, empty: push accepted, pop is an underflow, count becomes 1.
//  - Mode change: registered mode updates when join_mode differs from it. In that same edge
//    both FIFOs flush (pointers/counts 0), that cycle's push/pop are ignored, and flags are kept.
//  - err_clr: clears flags at the edge; a same-cycle error event wins (flag stays 1).
//  - Counts never exceed capacity; full = (count == capacity).
// STRUCTURE
//  - types.svh: fifo_join_t enum (2-bit); reuse the existing fifo_status struct.
//  - Sub-module fifo_ctrl (x2): head/tail/count, full/empty, error detection,
//    with runtime capacity and base-offset inputs. The top owns the shared storage and the mode register.
// TESTING (DEPTH=4, WIDTH=32)
//  - Reset mid-traffic: 3 TX pushes, drop rst for 1 cycle -> tx_count=0, empty=1,
//    tx_data_out=0, all flags 0.
//  - JOIN_NONE: push 0xA0..0xA4 (5 words) to TX -> count 4, full, tx_overflow=1;
//    pull 4 -> A0..A3 in order, then empty.
//  - JOIN_TX: push 8 words -> tx_count=8, full only after the 8th; rx_status={1,1}; rx_push ignored,
//    rx_overflow=0.
//  - Full TX, push 0xB5 + pull same cycle -> head advances, count stays 4, 0xB5 is last out.
//  - Empty RX, rx_push 0xC1 + rx_pop same cycle -> rx_underflow=1, rx_count=1,
//    rx_data_out=0xC1 next cycle.
//  - With 2 words in TX, switch JOIN_NONE->JOIN_RX -> both counts 0 next cycle; a push in the switch
//    cycle is dropped; flags are unchanged by the flush; err_clr clears them.

Source files
------------

// File: rtl/sm_fifo_pair_pkg.sv
// Shared types for the per-state-machine TX/RX FIFO pair.
package sm_fifo_pair_pkg;

  // Storage pooling mode. Encoding 3 is reserved and behaves as JOIN_NONE.
  typedef enum logic [1:0] {
    JOIN_NONE = 2'd0,
    JOIN_TX   = 2'd1,
    JOIN_RX   = 2'd2
  } fifo_join_t;

  // FIFO status as seen by software: {full, empty}.
  typedef struct packed {
    logic full;
    logic empty;
  } fifo_status_t;

  // Map the raw 2-bit mode input onto a legal mode; the reserved code folds to JOIN_NONE.
  function automatic fifo_join_t decode_join(input logic [1:0] raw);
    case (raw)
      2'd1:    return JOIN_TX;
      2'd2:    return JOIN_RX;
      default: return JOIN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sm_fifo_pair_fifo_ctrl.sv
// Pointer/occupancy controller for one FIFO living in a window of the shared
// storage array. Capacity and window base are runtime inputs so the same
// controller serves both the split and the pooled layouts.
module sm_fifo_pair_fifo_ctrl
  import sm_fifo_pair_pkg::*;
#(
  parameter int CNT_W = 4,
  localparam int PTR_W = CNT_W - 1
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             enable,     // FIFO exists in the current mode
  input  logic             flush,      // mode change: clear pointers, ignore requests
  input  logic [CNT_W-1:0] capacity,
  input  logic [PTR_W-1:0] base,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_addr,
  output logic [PTR_W-1:0] rd_addr,
  output logic [CNT_W-1:0] count,
  output fifo_status_t     status,
  output logic             overflow,
  output logic             underflow
);

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg, underflow_reg;

  logic             full_c, empty_c;
  logic             do_push, do_pop;
  logic             ovf_evt, unf_evt;
  logic [PTR_W-1:0] head_next, tail_next;
  logic [CNT_W-1:0] count_next;

  // Advance a window-relative pointer, wrapping at the current capacity.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr,
                                                input logic [CNT_W-1:0] cap);
    logic [CNT_W-1:0] nxt;
    nxt = {1'b0, ptr} + 1'b1;
    return (nxt == cap) ? '0 : nxt[PTR_W-1:0];
  endfunction

  assign full_c  = (count_reg == capacity);
  assign empty_c = (count_reg == '0);

  // Request qualification: a push into a full FIFO is still accepted when a
  // pop frees the head in the same cycle; a flush cycle swallows everything.
  always_comb begin
    do_pop     = enable && !flush && pop && !empty_c;
    do_push    = enable && !flush && push && (!full_c || do_pop);
    ovf_evt    = enable && !flush && push && !do_push;
    unf_evt    = enable && !flush && pop && empty_c;
    head_next  = do_pop  ? wrap_inc(head_reg, capacity) : head_reg;
    tail_next  = do_push ? wrap_inc(tail_reg, capacity) : tail_reg;
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy state; a flush returns the FIFO to empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Sticky error flags; a fresh error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (ovf_evt)      overflow_reg <= 1'b1;
      else if (err_clr) overflow_reg <= 1'b0;
      if (unf_evt)      underflow_reg <= 1'b1;
      else if (err_clr) underflow_reg <= 1'b0;
    end
  end

  assign wr_en        = do_push;
  assign wr_addr      = base + tail_reg;
  assign rd_addr      = base + head_reg;
  // A disabled FIFO reports itself as both full and empty with no occupancy.
  assign count        = enable ? count_reg : '0;
  assign status.full  = !enable || full_c;
  assign status.empty = !enable || empty_c;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: rtl/sm_fifo_pair.sv
// TX/RX FIFO pair for one state machine. Both FIFOs share a single
// 2*DEPTH-entry array; the join mode hands the whole array to one direction.
// Index 0 of the per-direction arrays is TX, index 1 is RX.
module sm_fifo_pair
  import sm_fifo_pair_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(2 * DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic [1:0]       join_mode,
  input  logic             tx_push_en,
  input  logic [WIDTH-1:0] tx_data_in,
  input  logic             tx_pull_en,
  output logic [WIDTH-1:0] tx_data_out,
  input  logic             rx_push_en,
  input  logic [WIDTH-1:0] rx_data_in,
  input  logic             rx_pop_en,
  output logic [WIDTH-1:0] rx_data_out,
  output fifo_status_t     tx_status,
  output fifo_status_t     rx_status,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  input  logic             err_clr,
  output logic             tx_overflow,
  output logic             tx_underflow,
  output logic             rx_overflow,
  output logic             rx_underflow
);

  localparam int PTR_W   = CNT_W - 1;
  localparam int ENTRIES = 2 * DEPTH;

  fifo_join_t       mode_reg;
  fifo_join_t       join_dec;
  logic             mode_change;

  logic [1:0]       dir_enable, dir_push, dir_pop, dir_wr_en, dir_ovf, dir_unf;
  logic [CNT_W-1:0] dir_capacity [2];
  logic [CNT_W-1:0] dir_count    [2];
  logic [PTR_W-1:0] dir_base     [2];
  logic [PTR_W-1:0] dir_wr_addr  [2];
  logic [PTR_W-1:0] dir_rd_addr  [2];
  logic [WIDTH-1:0] dir_wdata    [2];
  logic [WIDTH-1:0] dir_rdata    [2];
  fifo_status_t     dir_status   [2];

  logic [WIDTH-1:0] mem [ENTRIES];

  assign join_dec    = decode_join(join_mode);
  assign mode_change = (join_dec != mode_reg);

  // Mode register: follows the decoded input; every change flushes both FIFOs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mode_reg <= JOIN_NONE;
    else if (mode_change) mode_reg <= join_dec;
  end

  // Window layout: split mode gives TX the low half and RX the high half;
  // a joined direction owns the whole array starting at entry 0.
  assign dir_enable[0]   = (mode_reg != JOIN_RX);
  assign dir_enable[1]   = (mode_reg != JOIN_TX);
  assign dir_capacity[0] = (mode_reg == JOIN_TX) ? CNT_W'(ENTRIES) : CNT_W'(DEPTH);
  assign dir_capacity[1] = (mode_reg == JOIN_RX) ? CNT_W'(ENTRIES) : CNT_W'(DEPTH);
  assign dir_base[0]     = '0;
  assign dir_base[1]     = (mode_reg == JOIN_RX) ? '0 : PTR_W'(DEPTH);

  assign dir_push[0]  = tx_push_en;
  assign dir_pop[0]   = tx_pull_en;
  assign dir_wdata[0] = tx_data_in;
  assign dir_push[1]  = rx_push_en;
  assign dir_pop[1]   = rx_pop_en;
  assign dir_wdata[1] = rx_data_in;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dir
      sm_fifo_pair_fifo_ctrl #(
        .CNT_W(CNT_W)
      ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .enable   (dir_enable[gi]),
        .flush    (mode_change),
        .capacity (dir_capacity[gi]),
        .base     (dir_base[gi]),
        .push     (dir_push[gi]),
        .pop      (dir_pop[gi]),
        .err_clr  (err_clr),
        .wr_en    (dir_wr_en[gi]),
        .wr_addr  (dir_wr_addr[gi]),
        .rd_addr  (dir_rd_addr[gi]),
        .count    (dir_count[gi]),
        .status   (dir_status[gi]),
        .overflow (dir_ovf[gi]),
        .underflow(dir_unf[gi])
      );

      // First-word-fall-through head; an empty or disabled FIFO reads as zero.
      assign dir_rdata[gi] = (dir_count[gi] != '0) ? mem[dir_rd_addr[gi]] : '0;
    end
  endgenerate

  // Shared storage writes; the two windows never overlap while both are active.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dir_wr_en[i]) mem[dir_wr_addr[i]] <= dir_wdata[i];
    end
  end

  assign tx_data_out  = dir_rdata[0];
  assign rx_data_out  = dir_rdata[1];
  assign tx_status    = dir_status[0];
  assign rx_status    = dir_status[1];
  assign tx_count     = dir_count[0];
  assign rx_count     = dir_count[1];
  assign tx_overflow  = dir_ovf[0];
  assign tx_underflow = dir_unf[0];
  assign rx_overflow  = dir_ovf[1];
  assign rx_underflow = dir_unf[1];

endmodule

// File: tb/tb_sm_fifo_pair.sv
// Directed bench for sm_fifo_pair (DEPTH=4, WIDTH=32). Pulled/popped words
// are checked by a negedge monitor against scoreboard queues filled by the
// stimulus; status, counts and flags are checked directly after each step.
module tb_sm_fifo_pair;
  import sm_fifo_pair_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(2 * DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       join_mode;
  logic             tx_push_en, tx_pull_en, rx_push_en, rx_pop_en, err_clr;
  logic [WIDTH-1:0] tx_data_in, rx_data_in, tx_data_out, rx_data_out;
  fifo_status_t     tx_status, rx_status;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic             tx_overflow, tx_underflow, rx_overflow, rx_underflow;

  int n_vec = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] tx_q[$];
  logic [WIDTH-1:0] rx_q[$];

  sm_fifo_pair #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .join_mode(join_mode),
    .tx_push_en(tx_push_en), .tx_data_in(tx_data_in),
    .tx_pull_en(tx_pull_en), .tx_data_out(tx_data_out),
    .rx_push_en(rx_push_en), .rx_data_in(rx_data_in),
    .rx_pop_en(rx_pop_en), .rx_data_out(rx_data_out),
    .tx_status(tx_status), .rx_status(rx_status),
    .tx_count(tx_count), .rx_count(rx_count),
    .err_clr(err_clr),
    .tx_overflow(tx_overflow), .tx_underflow(tx_underflow),
    .rx_overflow(rx_overflow), .rx_underflow(rx_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      $display("ok   %s = %h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted pull/pop is compared with the oldest expected word.
  always @(negedge clk) begin
    if (rst && tx_pull_en && !tx_status.empty) begin
      if (tx_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL tx_pull: got %h, expected no word", tx_data_out);
      end else chk("tx_pull", tx_data_out, tx_q.pop_front());
    end
    if (rst && rx_pop_en && !rx_status.empty) begin
      if (rx_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL rx_pop: got %h, expected no word", rx_data_out);
      end else chk("rx_pop", rx_data_out, rx_q.pop_front());
    end
  end

  task automatic tx_push_words(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      tx_push_en = 1'b1; tx_data_in = first + 32'(i);
      tick();
    end
    tx_push_en = 1'b0;
  endtask

  task automatic tx_pull_n(input int n);
    tx_pull_en = 1'b1;
    repeat (n) tick();
    tx_pull_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; join_mode = 2'd0; err_clr = 1'b0;
    tx_push_en = 1'b0; tx_pull_en = 1'b0; rx_push_en = 1'b0; rx_pop_en = 1'b0;
    tx_data_in = '0; rx_data_in = '0;
    repeat (2) tick();
    chk("rst_tx_count", 32'(tx_count), 0);
    chk("rst_tx_status", 32'(tx_status), 32'b01);
    chk("rst_rx_status", 32'(rx_status), 32'b01);
    chk("rst_tx_data", tx_data_out, 0);
    rst = 1'b1;
    tick();

    // Reset mid-traffic
    tx_push_words(32'h11, 3);
    chk("pre_rst_tx_count", 32'(tx_count), 3);
    rst = 1'b0; tick(); rst = 1'b1; tick();
    chk("midrst_tx_count", 32'(tx_count), 0);
    chk("midrst_tx_empty", 32'(tx_status.empty), 1);
    chk("midrst_tx_data", tx_data_out, 0);
    chk("midrst_flags", {28'd0, tx_overflow, tx_underflow, rx_overflow, rx_underflow}, 0);

    // JOIN_NONE: overfill TX, then drain in order
    tx_push_words(32'hA0, 5);
    chk("none_tx_count", 32'(tx_count), 4);
    chk("none_tx_status", 32'(tx_status), 32'b10);
    chk("none_tx_ovf", 32'(tx_overflow), 1);
    for (int i = 0; i < 4; i++) tx_q.push_back(32'hA0 + 32'(i));
    tx_pull_n(4);
    chk("drain_tx_status", 32'(tx_status), 32'b01);
    chk("drain_tx_data", tx_data_out, 0);
    chk("drain_tx_unf", 32'(tx_underflow), 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_tx_ovf", 32'(tx_overflow), 0);

    // Full TX: simultaneous push and pull
    tx_push_words(32'hB1, 4);
    tx_push_en = 1'b1; tx_data_in = 32'hB5; tx_pull_en = 1'b1;
    tx_q.push_back(32'hB1);
    tick();
    tx_push_en = 1'b0; tx_pull_en = 1'b0;
    chk("fullpp_tx_count", 32'(tx_count), 4);
    chk("fullpp_tx_ovf", 32'(tx_overflow), 0);
    for (int i = 0; i < 4; i++) tx_q.push_back(32'hB2 + 32'(i));
    tx_pull_n(4);
    chk("fullpp_tx_count_end", 32'(tx_count), 0);

    // Empty RX: simultaneous push and pop
    rx_push_en = 1'b1; rx_data_in = 32'hC1; rx_pop_en = 1'b1;
    tick();
    rx_push_en = 1'b0; rx_pop_en = 1'b0;
    chk("emptypp_rx_unf", 32'(rx_underflow), 1);
    chk("emptypp_rx_count", 32'(rx_count), 1);
    chk("emptypp_rx_data", rx_data_out, 32'hC1);
    rx_q.push_back(32'hC1);
    rx_pop_en = 1'b1; tick(); rx_pop_en = 1'b0;
    chk("emptypp_rx_count_end", 32'(rx_count), 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_rx_unf", 32'(rx_underflow), 0);

    // JOIN_TX: TX capacity 8, RX disabled
    join_mode = 2'd1; tick();
    for (int i = 0; i < 8; i++) begin
      tx_push_en = 1'b1; tx_data_in = 32'hD0 + 32'(i);
      tick();
      if (i == 6) begin
        chk("jtx_count7", 32'(tx_count), 7);
        chk("jtx_full7", 32'(tx_status.full), 0);
      end
    end
    tx_push_en = 1'b0;
    chk("jtx_count8", 32'(tx_count), 8);
    chk("jtx_status8", 32'(tx_status), 32'b10);
    chk("jtx_rx_status", 32'(rx_status), 32'b11);
    rx_push_en = 1'b1; rx_data_in = 32'hEE; tick(); rx_push_en = 1'b0;
    chk("jtx_rx_count", 32'(rx_count), 0);
    chk("jtx_rx_ovf", 32'(rx_overflow), 0);
    chk("jtx_rx_data", rx_data_out, 0);
    for (int i = 0; i < 8; i++) tx_q.push_back(32'hD0 + 32'(i));
    tx_pull_n(8);
    chk("jtx_drained", 32'(tx_status), 32'b01);

    // Mode switch flushes both FIFOs, keeps flags, drops switch-cycle push
    join_mode = 2'd0; tick();
    tx_push_words(32'hE0, 2);
    rx_push_en = 1'b1; rx_data_in = 32'h77; tick(); rx_push_en = 1'b0;
    rx_pop_en = 1'b1; rx_q.push_back(32'h77); tick();
    rx_pop_en = 1'b1; tick(); rx_pop_en = 1'b0;
    chk("sw_pre_rx_unf", 32'(rx_underflow), 1);
    chk("sw_pre_tx_count", 32'(tx_count), 2);
    join_mode = 2'd2; rx_push_en = 1'b1; rx_data_in = 32'h99;
    tx_push_en = 1'b1; tx_data_in = 32'hF0;
    tick();
    rx_push_en = 1'b0; tx_push_en = 1'b0;
    chk("sw_tx_count", 32'(tx_count), 0);
    chk("sw_rx_count", 32'(rx_count), 0);
    chk("sw_tx_status", 32'(tx_status), 32'b11);
    chk("sw_rx_unf_kept", 32'(rx_underflow), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("sw_clr_rx_unf", 32'(rx_underflow), 0);

    // JOIN_RX: RX capacity 8
    for (int i = 0; i < 8; i++) begin
      rx_push_en = 1'b1; rx_data_in = 32'h80 + 32'(i);
      rx_q.push_back(32'h80 + 32'(i));
      tick();
    end
    rx_push_en = 1'b0;
    chk("jrx_count8", 32'(rx_count), 8);
    chk("jrx_status8", 32'(rx_status), 32'b10);
    rx_pop_en = 1'b1; repeat (8) tick(); rx_pop_en = 1'b0;
    chk("jrx_drained", 32'(rx_status), 32'b01);

    tick();
    chk("tx_queue_left", 32'(tx_q.size()), 0);
    chk("rx_queue_left", 32'(rx_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
